uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver_pkg.sv | 21 ++
 rtl/uart_fifo.sv | 46 ++++
 rtl/uart_receiver.sv | 127 ++++++++++++
 tb/tb_uart_receiver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: shared parameter defaults, FSM state encodings and the CLEAR macro (UART_RX_PARITY_EN adds the PARITY state)
`ifndef CLEAR
`define CLEAR(sig) sig <= '0
`endif

package uart_receiver_pkg;
    localparam int DEFAULT_UART_DATA_BITS      = 8;
    localparam int DEFAULT_UART_SB_TICKS       = 16;
    localparam int DEFAULT_UART_BAUD_DIVISOR   = 326;
    localparam int DEFAULT_UART_FIFO_ADDR_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO with overrun pulse; storage is not reset
module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         empty,
    output logic         full,
    output logic         overrun
);
    import uart_receiver_pkg::*;

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty    = count == '0;
    assign full     = count == (AW+1)'(2**AW);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign data_out = empty ? '0 : mem[rd_ptr];

    // storage write, deliberately without reset
    always_ff @(posedge i_clk)
        if (do_push) mem[wr_ptr] <= data_in;

    // pointers wrap naturally modulo depth; count tracks occupancy
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            `CLEAR(wr_ptr);
            `CLEAR(rd_ptr);
            `CLEAR(count);
            `CLEAR(overrun);
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            overrun <= push & full & ~pop;
        end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver feeding a FIFO; define UART_RX_PARITY_EN for even-parity checking
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int DATA_BITS      = DEFAULT_UART_DATA_BITS,
    parameter int SB_TICKS       = DEFAULT_UART_SB_TICKS,
    parameter int BAUD_DIVISOR   = DEFAULT_UART_BAUD_DIVISOR,
    parameter int FIFO_ADDR_BITS = DEFAULT_UART_FIFO_ADDR_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_rd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_frame_error,
    output logic                 o_overrun
);
    localparam int BW = BAUD_DIVISOR > 1 ? $clog2(BAUD_DIVISOR) : 1;
    localparam int NW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;

    logic                 rx_meta, rx;
    logic [BW-1:0]        baud_cnt;
    logic                 tick;
    state_t               state;
    logic [4:0]           s;
    logic [NW-1:0]        n;
    logic [DATA_BITS-1:0] shift;
    logic                 frame_ok, push;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad;
    assign frame_ok = rx & ~parity_bad;
`else
    assign frame_ok = rx;
`endif

    assign tick = baud_cnt == BW'(BAUD_DIVISOR - 1);
    assign push = tick && state == ST_STOP && s == 5'(SB_TICKS - 1) && frame_ok;

    // two-flop synchronizer, resets to the idle-high line level
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) {rx_meta, rx} <= 2'b11;
        else {rx_meta, rx} <= {i_rx, rx_meta};

    // free-running oversampling tick generator
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) `CLEAR(baud_cnt);
        else baud_cnt <= tick ? '0 : baud_cnt + 1'b1;

    // frame FSM: start at mid-bit, sample each bit every 16 ticks, report bad frames at stop
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            state <= ST_IDLE;
            `CLEAR(s);
            `CLEAR(n);
            `CLEAR(shift);
            `CLEAR(o_frame_error);
`ifdef UART_RX_PARITY_EN
            `CLEAR(parity_bad);
`endif
        end else begin
            o_frame_error <= 1'b0;
            case (state)
                ST_IDLE:
                    if (!rx) begin
                        state <= ST_START;
                        s     <= '0;
                    end
                ST_START:
                    if (tick) begin
                        if (s == 5'd7) begin
                            state <= rx ? ST_IDLE : ST_DATA;
                            s     <= '0;
                            n     <= '0;
`ifdef UART_RX_PARITY_EN
                            parity_bad <= 1'b0;
`endif
                        end else s <= s + 1'b1;
                    end
                ST_DATA:
                    if (tick) begin
                        if (s == 5'd15) begin
                            s     <= '0;
                            n     <= n + 1'b1;
                            shift <= {rx, shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                            if (n == NW'(DATA_BITS - 1)) state <= ST_PARITY;
`else
                            if (n == NW'(DATA_BITS - 1)) state <= ST_STOP;
`endif
                        end else s <= s + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                ST_PARITY:
                    if (tick) begin
                        if (s == 5'd15) begin
                            s          <= '0;
                            parity_bad <= ^{shift, rx};
                            state      <= ST_STOP;
                        end else s <= s + 1'b1;
                    end
`endif
                ST_STOP:
                    if (tick) begin
                        if (s == 5'(SB_TICKS - 1)) begin
                            s             <= '0;
                            o_frame_error <= ~frame_ok;
                            state         <= ST_IDLE;
                        end else s <= s + 1'b1;
                    end
                default: state <= ST_IDLE;
            endcase
        end

    uart_fifo #(.W(DATA_BITS), .AW(FIFO_ADDR_BITS)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (push),
        .pop     (i_rd),
        .data_in (shift),
        .data_out(o_data),
        .empty   (o_empty),
        .full    (o_full),
        .overrun (o_overrun)
    );
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: frame-level bench with a queue reference model, vector table and corner sequences
module tb_uart_receiver;
    logic       clk = 1'b0;
    logic       i_reset, i_rx, i_rd;
    logic [7:0] o_data;
    logic       o_empty, o_full, o_frame_error, o_overrun;

    int n_vec = 0, n_bad = 0;
    int fe_cnt = 0, ov_cnt = 0, empty_data_bad = 0;
    int exp_fe = 0, exp_ov = 0;
    logic [7:0] q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       exp_empty;
        logic [7:0] exp_head;
        int         exp_fe;
    } vec_t;
    vec_t tbl[6];

    uart_receiver #(.BAUD_DIVISOR(4)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_rx         (i_rx),
        .i_rd         (i_rd),
        .o_data       (o_data),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_frame_error(o_frame_error),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_frame_error) fe_cnt <= fe_cnt + 1;
        if (o_overrun) ov_cnt <= ov_cnt + 1;
        if (o_empty && o_data != 8'h00) empty_data_bad <= empty_data_bad + 1;
    end

    task automatic tk(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // 64 clocks per bit; a bad stop bit is held low only 48 clocks so the line recovers before a false start
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        i_rx = 1'b0;
        tk(64);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            tk(64);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = par_ok ? ^d : ~^d;
        tk(64);
`endif
        i_rx = stop_ok;
        tk(stop_ok ? 64 : 48);
        i_rx = 1'b1;
        tk(128);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic ok);
        if (!ok) exp_fe++;
        else if (q.size() == 16) exp_ov++;
        else q.push_back(d);
    endtask

    task automatic frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        send_frame(d, stop_ok, par_ok);
        model_frame(d, stop_ok && par_ok);
    endtask

    task automatic pop();
        i_rd = 1'b1;
        tk(1);
        i_rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic check_state(input string tag);
        check({tag, "_empty"}, o_empty, q.size() == 0);
        check({tag, "_full"}, o_full, q.size() == 16);
        check({tag, "_data"}, o_data, q.size() != 0 ? q[0] : 8'h00);
        check({tag, "_fe"}, fe_cnt, exp_fe);
        check({tag, "_ov"}, ov_cnt, exp_ov);
    endtask

    initial begin
        tbl[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 0};
        tbl[1] = '{8'hA3, 1'b0, 1'b1, 8'h00, 1};
        tbl[2] = '{8'hC4, 1'b1, 1'b0, 8'hC4, 0};
        tbl[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 0};
        tbl[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 0};
        tbl[5] = '{8'h81, 1'b0, 1'b1, 8'h00, 1};

        i_reset = 1'b1;
        i_rx    = 1'b1;
        i_rd    = 1'b0;
        tk(5);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_data", o_data, 0);
        check("rst_fe", o_frame_error, 0);
        check("rst_ov", o_overrun, 0);
        i_reset = 1'b0;
        tk(10);

        for (int i = 0; i < 6; i++) begin
            int fe0;
            fe0 = fe_cnt;
            send_frame(tbl[i].data, tbl[i].stop_ok, 1'b1);
            exp_fe += tbl[i].exp_fe;
            check("tbl_empty", o_empty, tbl[i].exp_empty);
            check("tbl_data", o_data, tbl[i].exp_head);
            check("tbl_fe", fe_cnt - fe0, tbl[i].exp_fe);
            if (!tbl[i].exp_empty) begin
                i_rd = 1'b1;
                tk(1);
                i_rd = 1'b0;
                check("tbl_pop_empty", o_empty, 1);
                check("tbl_pop_data", o_data, 0);
            end
        end

        i_rx = 1'b0;
        tk(16);
        i_rx = 1'b1;
        tk(200);
        check_state("glitch");

        pop();
        check_state("rd_empty");

        for (int i = 0; i <= 16; i++) begin
            frame(8'(i), 1'b1, 1'b1);
            if (i == 15) check("fill_full", o_full, 1);
        end
        check_state("overrun");
        for (int i = 0; i < 16; i++) begin
            check("drain_data", o_data, 8'(i));
            pop();
        end
        check_state("drained");

        frame(8'h12, 1'b1, 1'b1);
        check_state("pre_rst");
        i_rx = 1'b0;
        tk(64);
        for (int i = 0; i < 3; i++) begin
            i_rx = (8'h3C >> i) & 8'h01;
            tk(64);
        end
        i_rx = 1'b1;
        tk(30);
        i_reset = 1'b1;
        tk(1);
        q.delete();
        check("mid_rst_empty", o_empty, 1);
        check("mid_rst_full", o_full, 0);
        check("mid_rst_data", o_data, 0);
        check("mid_rst_fe", o_frame_error, 0);
        check("mid_rst_ov", o_overrun, 0);
        tk(3);
        i_reset = 1'b0;
        tk(128);
        frame(8'h3C, 1'b1, 1'b1);
        check_state("post_rst");
        pop();

`ifdef UART_RX_PARITY_EN
        frame(8'h0F, 1'b1, 1'b0);
        check_state("par_bad");
        frame(8'h0F, 1'b1, 1'b1);
        check_state("par_good");
        pop();
`endif

        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic       stop_ok, par_ok;
            d       = 8'($urandom);
            stop_ok = $urandom_range(0, 6) != 0;
`ifdef UART_RX_PARITY_EN
            par_ok = $urandom_range(0, 4) != 0;
`else
            par_ok = 1'b1;
`endif
            frame(d, stop_ok, par_ok);
            check_state("rand");
            repeat ($urandom_range(0, 1)) begin
                pop();
                check_state("rand_pop");
            end
        end

        check("empty_data_zero", empty_data_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
